clk_step_ctrl: RTL and testbench
================================

Name: clk_step_ctrl

Overview:
Parametrised successor to the board clock divider that slows the 50 MHz board clock into the processor clock. It adds run, fast-run, halt and single-step modes. Single step uses a debounced push-button and produces one clean clock pulse per press. It also provides a single-cycle tick strobe and a count of issued processor cycles. It sits in the FPGA top level between the board clock/switches/keys and the processor core and display logic.

Parameters:
CNT_W, 31, width of the half-period counter
RUN_HALF, 25000000, half-period in clk cycles for RUN mode (1 Hz at 50 MHz)
FAST_HALF, 2500000, half-period in clk cycles for FAST mode
STEP_HALF, 1000, high-phase length in clk cycles of a single-step pulse
DB_CYCLES, 1000000, stable cycles required to accept a button level change (20 ms)
CYC_W, 32, width of cycle_cnt

Ports:
clk  input  1  board clock
rst  input  1  asynchronous active-low reset
mode  input  2  switch input: 00 HALT, 01 RUN, 10 FAST, 11 STEP; asynchronous
step_btn  input  1  raw push-button, active-low (pressed = 0); asynchronous
out_clk  output  1  divided processor clock, registered
tick  output  1  one-clk pulse in the cycle out_clk goes 0->1
cycle_cnt  output  CYC_W  number of out_clk rising edges since reset
running  output  1  1 while in RUN or FAST state

Behaviour:
- Reset (rst=0, async, immediate): out_clk=0, tick=0, cycle_cnt=0, running=0, counter=0, FSM=IDLE, debouncer=released, sync flops=0/1 released.
- mode passes through a 2-flop synchroniser and takes effect 2 clk cycles after it changes. step_btn passes through a 2-flop synchroniser and then the debouncer.
- Debouncer: the accepted level changes only after the synced input differs from it for DB_CYCLES consecutive cycles. A shorter glitch is ignored and its counter restarts. A press event is a 1-cycle pulse on the accepted 1->0 transition.
- FSM states: IDLE, RUN_LO, RUN_HI, STEP_HI.
- IDLE: out_clk=0, counter held at 0.
  - Synced mode RUN or FAST -> RUN_LO with counter=0.
  - Press event while mode=STEP -> STEP_HI; out_clk=1 and tick=1 in that same cycle.
  - Press events in HALT, RUN or FAST are discarded.
- RUN_LO and RUN_HI: half length H is latched at the start of each half: RUN_HALF or FAST_HALF from the current synced mode.
  - Counter counts 0..H-1, so each half is exactly H clk cycles and the period is 2H.
  - At the end of RUN_LO: if mode is RUN/FAST -> RUN_HI, out_clk=1, tick=1. Otherwise -> IDLE.
  - At the end of RUN_HI: -> RUN_LO, out_clk=0.
  - A mode change never truncates a phase. A high phase always completes.
  - HALT/STEP selected during RUN_HI: the high phase completes, the low phase begins, and the FSM stops in IDLE at the end of that low phase.
- STEP_HI: out_clk=1 for exactly STEP_HALF cycles, then -> IDLE with out_clk=0. Press events during STEP_HI are discarded.
- cycle_cnt increments by 1 in every cycle tick=1 and wraps modulo 2^CYC_W.
- running=1 in RUN_LO/RUN_HI, 0 otherwise.
- All outputs are registered; no combinational path from inputs to outputs.
- Width rules:
  - Counter compare is exact equality to H-1 in CNT_W bits.
  - RUN_HALF, FAST_HALF and STEP_HALF must be ≥1 and <2^CNT_W.
  - DB_CYCLES uses a counter of width $clog2(DB_CYCLES+1).

Decomposition:
- Shared package clk_ctrl_pkg: mode encodings MODE_HALT/RUN/FAST/STEP; FSM state encodings.
- Sub-module btn_debounce (synchroniser, stability counter, falling-edge press pulse), parametrised by DB_CYCLES.

Test Plan:
All scenarios use RUN_HALF=4, FAST_HALF=2, STEP_HALF=3, DB_CYCLES=8 unless stated.
- Reset, then mode=01 -> out_clk low for 2 sync + 4 cycles, then rises. After that, period 8 (4 high/4 low), tick every 8 cycles coincident with the rise, cycle_cnt 1,2,3…, running=1.
- RUN, mode 01->10 two cycles into a high phase -> that high phase lasts 4 cycles total. Subsequent halves are 2 cycles (period 4).
- mode=11, step_btn low for 20 cycles then high -> exactly one out_clk high pulse of 3 cycles, cycle_cnt +1. A 5-cycle low glitch -> no pulse, cycle_cnt unchanged.
- RUN, mode 01->00 mid-high -> high completes, low phase completes, then out_clk stays 0, running=0, cycle_cnt frozen. A press in HALT -> no pulse.
- rst asserted mid-high -> out_clk=0, cycle_cnt=0, tick=0 immediately, without waiting for clk.
- CYC_W=4, FAST mode -> after 16 rising edges cycle_cnt reads 0 (wrap).

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg: mode switch encodings and controller state encodings, rev 1.0
`default_nettype none

package clk_ctrl_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_LO  = 2'd1,
    ST_RUN_HI  = 2'd2,
    ST_STEP_HI = 2'd3
  } state_e;

  function automatic logic is_free_running(input logic [1:0] m);
    return (m == MODE_RUN) || (m == MODE_FAST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// btn_debounce: active-low button synchroniser, stability filter and press pulse, rev 1.0
`default_nettype none

module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned     DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            press_q;
  logic [DB_W-1:0] cnt_q;
  logic            differ;
  logic            accept;

  assign differ = (sync2_q != level_q);
  // Accept on the DB_CYCLES-th consecutive differing sample.
  assign accept = differ && (cnt_q == DB_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= accept && !sync2_q;
      if (accept) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else if (differ) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: processor clock generator with halt, run, fast-run and single-step modes, rev 1.0
`default_nettype none

module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 31,
  parameter int unsigned RUN_HALF  = 25000000,
  parameter int unsigned FAST_HALF = 2500000,
  parameter int unsigned STEP_HALF = 1000,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CYC_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  output logic             out_clk,
  output logic             tick,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic             running
);

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_HALF - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_HALF - 1);

  logic [1:0]       mode_s1_q;
  logic [1:0]       mode_s2_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_q;
  logic             out_clk_q;
  logic             tick_q;
  logic             running_q;
  logic [CYC_W-1:0] cyc_q;

  logic             press;
  logic             go;
  logic             phase_end;
  logic [CNT_W-1:0] half_last_d;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (step_btn),
    .press_o (press)
  );

  assign go          = is_free_running(mode_s2_q);
  // Halt/step during a high phase still gets a full RUN-length low phase.
  assign half_last_d = (mode_s2_q == MODE_FAST) ? FAST_LAST : RUN_LAST;
  assign phase_end   = (cnt_q == last_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_s1_q <= MODE_HALT;
      mode_s2_q <= MODE_HALT;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= '0;
      out_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      cyc_q     <= '0;
    end else begin
      mode_s1_q <= mode;
      mode_s2_q <= mode_s1_q;
      tick_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q     <= '0;
          out_clk_q <= 1'b0;
          if (go) begin
            state_q   <= ST_RUN_LO;
            last_q    <= half_last_d;
            running_q <= 1'b1;
          end else if (press && (mode_s2_q == MODE_STEP)) begin
            state_q   <= ST_STEP_HI;
            last_q    <= STEP_LAST;
            out_clk_q <= 1'b1;
            tick_q    <= 1'b1;
            cyc_q     <= cyc_q + 1'b1;
          end
        end
        ST_RUN_LO: begin
          if (phase_end) begin
            cnt_q <= '0;
            if (go) begin
              state_q   <= ST_RUN_HI;
              last_q    <= half_last_d;
              out_clk_q <= 1'b1;
              tick_q    <= 1'b1;
              cyc_q     <= cyc_q + 1'b1;
            end else begin
              state_q   <= ST_IDLE;
              running_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN_HI: begin
          if (phase_end) begin
            cnt_q     <= '0;
            state_q   <= ST_RUN_LO;
            last_q    <= half_last_d;
            out_clk_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STEP_HI: begin
          if (phase_end) begin
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            out_clk_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          out_clk_q <= 1'b0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_clk   = out_clk_q;
  assign tick      = tick_q;
  assign cycle_cnt = cyc_q;
  assign running   = running_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl: randomized stimulus against a phase-length reference model, rev 1.0
`default_nettype none

module tb_clk_step_ctrl;

  localparam int CNT_W     = 8;
  localparam int RUN_HALF  = 4;
  localparam int FAST_HALF = 2;
  localparam int STEP_HALF = 3;
  localparam int DB_CYCLES = 8;
  localparam int CYC_W     = 4;

  localparam int P_IDLE = 0;
  localparam int P_LOW  = 1;
  localparam int P_HIGH = 2;
  localparam int P_STEP = 3;

  logic             clk      = 1'b0;
  logic             rst      = 1'b0;
  logic [1:0]       mode     = 2'b00;
  logic             step_btn = 1'b1;
  logic             out_clk;
  logic             tick;
  logic [CYC_W-1:0] cycle_cnt;
  logic             running;

  int n_checks = 0;
  int n_pass   = 0;

  clk_step_ctrl #(
    .CNT_W     (CNT_W),
    .RUN_HALF  (RUN_HALF),
    .FAST_HALF (FAST_HALF),
    .STEP_HALF (STEP_HALF),
    .DB_CYCLES (DB_CYCLES),
    .CYC_W     (CYC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .step_btn  (step_btn),
    .out_clk   (out_clk),
    .tick      (tick),
    .cycle_cnt (cycle_cnt),
    .running   (running)
  );

  always #5 clk = ~clk;

  // Reference model: current phase and cycles left in it, plus input history.
  int         phase;
  int         remain;
  int         rises;
  bit         m_out;
  bit         m_tick;
  logic [1:0] mode_hist[$];
  bit         btn_hist[$];
  bit         acc;
  int         diff_run;
  bit         press_pend;

  function automatic int half_of(input logic [1:0] m);
    return (m == 2'b10) ? FAST_HALF : RUN_HALF;
  endfunction

  task automatic model_reset();
    phase      = P_IDLE;
    remain     = 0;
    rises      = 0;
    m_out      = 1'b0;
    m_tick     = 1'b0;
    mode_hist.delete();
    mode_hist.push_back(2'b00);
    mode_hist.push_back(2'b00);
    btn_hist.delete();
    btn_hist.push_back(1'b1);
    btn_hist.push_back(1'b1);
    acc        = 1'b1;
    diff_run   = 0;
    press_pend = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] sm;
    bit         sb;
    bit         pr;
    bit         go;
    sm = mode_hist[0];
    sb = btn_hist[0];
    void'(mode_hist.pop_front());
    mode_hist.push_back(mode);
    void'(btn_hist.pop_front());
    btn_hist.push_back(step_btn);
    pr         = press_pend;
    press_pend = 1'b0;
    go         = (sm == 2'b01) || (sm == 2'b10);
    m_tick     = 1'b0;
    case (phase)
      P_IDLE: begin
        if (go) begin
          phase  = P_LOW;
          remain = half_of(sm);
        end else if (pr && sm == 2'b11) begin
          phase  = P_STEP;
          remain = STEP_HALF;
          m_out  = 1'b1;
          m_tick = 1'b1;
          rises++;
        end
      end
      P_LOW: begin
        remain--;
        if (remain == 0) begin
          if (go) begin
            phase  = P_HIGH;
            remain = half_of(sm);
            m_out  = 1'b1;
            m_tick = 1'b1;
            rises++;
          end else begin
            phase = P_IDLE;
          end
        end
      end
      P_HIGH: begin
        remain--;
        if (remain == 0) begin
          phase  = P_LOW;
          remain = half_of(sm);
          m_out  = 1'b0;
        end
      end
      default: begin
        remain--;
        if (remain == 0) begin
          phase = P_IDLE;
          m_out = 1'b0;
        end
      end
    endcase
    if (sb != acc) begin
      diff_run++;
      if (diff_run == DB_CYCLES) begin
        acc        = sb;
        diff_run   = 0;
        press_pend = !sb;
      end
    end else begin
      diff_run = 0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_step();
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_outputs(input string where);
    check({where, ".out_clk"},   32'(out_clk),   32'(m_out));
    check({where, ".tick"},      32'(tick),      32'(m_tick));
    check({where, ".cycle_cnt"}, 32'(cycle_cnt), 32'(rises % (1 << CYC_W)));
    check({where, ".running"},   32'(running),   32'(phase == P_LOW || phase == P_HIGH));
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs("cyc");
    end
  endtask

  task automatic wait_rise();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      cycle(1);
      seen = m_tick;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL wait_rise: no rising edge within 50 cycles, got none required one");
    end
  endtask

  initial begin
    int len;
    int btn_left;

    model_reset();
    cycle(3);
    rst = 1'b1;

    // Plain RUN: start-up latency then period 2*RUN_HALF
    mode = 2'b01;
    cycle(40);

    // Switch to FAST two cycles into a high phase
    wait_rise();
    cycle(1);
    mode = 2'b10;
    cycle(70);

    // HALT mid-high, then a press while halted
    mode = 2'b01;
    cycle(12);
    wait_rise();
    cycle(1);
    mode = 2'b00;
    cycle(30);
    step_btn = 1'b0;
    cycle(20);
    step_btn = 1'b1;
    cycle(20);

    // Single step: one clean press, then a short glitch
    mode = 2'b11;
    cycle(4);
    step_btn = 1'b0;
    cycle(20);
    step_btn = 1'b1;
    cycle(20);
    step_btn = 1'b0;
    cycle(5);
    step_btn = 1'b1;
    cycle(20);

    // Asynchronous reset in the middle of a high phase
    mode = 2'b10;
    cycle(4);
    wait_rise();
    cycle(1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    mode = 2'b00;
    cycle(2);
    rst = 1'b1;
    cycle(4);

    // Random mode segments with random button activity
    btn_left = 0;
    for (int seg = 0; seg < 40; seg++) begin
      mode = 2'($urandom_range(0, 3));
      len  = int'($urandom_range(10, 40));
      for (int c = 0; c < len; c++) begin
        if (btn_left == 0) begin
          step_btn = ~step_btn;
          btn_left = step_btn ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 20));
        end
        btn_left--;
        cycle(1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
